// File: rtl/pc_gen.sv
// Fetch-address generator: prioritised redirects, trap override,
// alignment check with halt-until-trap, valid/ready request port.
//
// Ports:
//   clk, rst_n       clock, async active-low reset
//   redir_valid      per-source redirect pulse (index 0 wins)
//   redir_target     packed targets, source i at [i*XLEN +: XLEN]
//   trap_valid       trap redirect, overrides everything
//   trap_vector      trap target (assumed aligned)
//   fetch_valid      fetch_pc is a live request
//   fetch_ready      consumer accepts fetch_pc this cycle
//   fetch_pc         current fetch address
//   misalign_err     one-cycle pulse on a misaligned redirect
//   misalign_addr    last offending target
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int NUM_REDIR = 4,
  parameter int ALIGN_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REDIR-1:0]      redir_valid,
  input  logic [NUM_REDIR*XLEN-1:0] redir_target,
  input  logic                      trap_valid,
  input  logic [XLEN-1:0]           trap_vector,
  output logic                      fetch_valid,
  input  logic                      fetch_ready,
  output logic [XLEN-1:0]           fetch_pc,
  output logic                      misalign_err,
  output logic [XLEN-1:0]           misalign_addr
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [XLEN-1:0] ALIGN_MASK =
    XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] addr_q, addr_d;

  logic            sel_hit;
  logic [XLEN-1:0] sel_tgt;
  logic            sel_bad;

  // Scan from the top so the lowest asserted index is written last.
  always_comb begin
    sel_hit = 1'b0;
    sel_tgt = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) begin
        sel_hit = 1'b1;
        sel_tgt = redir_target[i*XLEN +: XLEN];
      end
    end
  end

  assign sel_bad = |(sel_tgt & ALIGN_MASK);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        if (trap_valid) pc_d = trap_vector;
      end
      ST_RUN: begin
        if (trap_valid) begin
          pc_d = trap_vector;
        end else if (sel_hit) begin
          if (sel_bad) begin
            err_d   = 1'b1;
            addr_d  = sel_tgt;
            state_d = ST_HALT;
          end else begin
            pc_d = sel_tgt;
          end
        end else if (valid_q && fetch_ready) begin
          pc_d = pc_q + PC_INC;
        end
      end
      ST_HALT: begin
        if (trap_valid) begin
          pc_d    = trap_vector;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
    // Registered so fetch_valid tracks the state being entered.
    valid_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  assign fetch_valid   = valid_q;
  assign fetch_pc      = pc_q;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the fetch stage. It replaces the fixed 32-bit PC register with a handshaked fetch-address source. It accepts prioritised redirects from any number of sources, checks target alignment, and halts on a misaligned target until a trap redirect arrives. It sits between the branch/jump resolution logic and the instruction-memory request port.

## Interface
- XLEN, 32: address width in bits.
- RESET_VECTOR, 0: first fetch address after reset.
- NUM_REDIR, 4: number of redirect sources; index 0 has the highest priority.
- ALIGN_BITS, 2: number of low target bits that must be zero; the increment is 4.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redir_valid  in  NUM_REDIR  per-source redirect request, single-cycle pulse.
- redir_target  in  NUM_REDIR*XLEN  targets; source i occupies bits [i*XLEN +: XLEN].
- trap_valid  in  1  trap redirect; overrides everything, including HALT.
- trap_vector  in  XLEN  trap target; must be aligned, not checked.
- fetch_valid  out  1  fetch_pc is a valid request.
- fetch_ready  in  1  the consumer accepts fetch_pc this cycle.
- fetch_pc  out  XLEN  current fetch address.
- misalign_err  out  1  one-cycle pulse: the selected redirect target was misaligned.
- misalign_addr  out  XLEN  offending target; held until the next misalign_err.

## Operation
- States:
  - BOOT: entered at reset.
  - RUN: normal fetch.
  - HALT: entered after a misaligned redirect.
- Reset values:
  - State = BOOT.
  - fetch_pc = RESET_VECTOR.
  - fetch_valid = 0.
  - misalign_err = 0.
  - misalign_addr = 0.
- BOOT moves to RUN on the first clock edge after rst_n deasserts. fetch_pc stays RESET_VECTOR.
- Next-PC priority in RUN, highest first:
  1. trap_valid → trap_vector.
  2. The lowest-index asserted redir_valid[i] → redir_target[i].
  3. If fetch_valid & fetch_ready → fetch_pc + 4, modulo 2^XLEN.
  4. Otherwise hold fetch_pc.
- Misaligned redirect: the target selected in step 2 has any of its low ALIGN_BITS bits nonzero.
  - fetch_pc is not updated.
  - misalign_err pulses for one cycle.
  - misalign_addr captures the target.
  - State moves to HALT.
  - Lower-priority redirects in the same cycle are discarded.
- HALT:
  - fetch_valid = 0 and fetch_pc holds.
  - redir_valid is ignored.
  - trap_valid loads trap_vector and moves the state to RUN.
- trap_valid in BOOT: loads trap_vector, and the state moves to RUN.
- A redirect overrides a pending, unaccepted request. fetch_pc may change while fetch_valid=1 & fetch_ready=0 only because of a redirect or trap. Otherwise it is stable until accepted.
- A redirect in the same cycle as an accept: the accepted address counts as consumed, and the next address is the redirect target, not pc+4.
- Wrap-around: 0xFFFF_FFFC + 4 = 0x0000_0000 (XLEN=32); no flag is raised.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Redirect/trap latency is 1 cycle: asserted at edge N, the target appears on fetch_pc after edge N, with fetch_valid=1.
- Sequential throughput is one address per cycle while fetch_ready=1.
- First request: fetch_valid rises 1 cycle after the rst_n release edge is sampled.
- misalign_err is asserted in the cycle after the offending redirect edge. fetch_valid drops in that same cycle.
- Reset mid-operation: outputs go to their reset values immediately and asynchronously. Any pending redirect is lost.

## Test plan
- Reset then fetch_ready=1 for 4 cycles:
  - fetch_valid rises 1 cycle after reset release.
  - fetch_pc sequence = 0x0, 0x4, 0x8, 0xC.
- fetch_ready=0 for 3 cycles at pc=0x10: fetch_pc stays 0x10 with fetch_valid=1. Release → 0x14.
- Same-cycle redir_valid=4'b0110 with targets[1]=0x100, targets[2]=0x200, plus an accept: next fetch_pc = 0x100.
- Misaligned redirect:
  - Stimulus: redir_valid[3] with target 0x202.
  - misalign_err pulses once and misalign_addr = 0x202.
  - fetch_valid=0 and later redirects to 0x300 are ignored.
  - trap_valid with trap_vector 0x80 → fetch_pc = 0x80, fetch_valid=1.
- Wrap-around: redirect to 0xFFFF_FFFC, then accept → fetch_pc = 0x0000_0000.
- Reset asserted while a request is stalled: fetch_valid=0 and fetch_pc=RESET_VECTOR immediately. Normal boot resumes after release.
